// File: rtl/mem_cond_branch_if.sv
// Command, memory-read and result signals of the load-and-branch unit.
// slave is the unit itself; master is the pipeline/memory side that drives it.
interface mem_cond_branch_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  start;
  logic [2:0]            cond;
  logic [ADDR_WIDTH-1:0] base;
  logic [15:0]           offset;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] target;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  busy;
  logic                  done;
  logic                  taken;
  logic                  fault;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic [DATA_WIDTH-1:0] load_value;
  logic                  rf_we;

  modport master (
    output start, cond, base, offset, pc_plus4, target, mem_ready, mem_rdata,
    input  mem_req, mem_addr, busy, done, taken, fault, next_pc, load_value, rf_we
  );

  modport slave (
    input  start, cond, base, offset, pc_plus4, target, mem_ready, mem_rdata,
    output mem_req, mem_addr, busy, done, taken, fault, next_pc, load_value, rf_we
  );
endinterface

// File: rtl/mem_cond_branch.sv
// Loads one word at base+offset, tests it against cond and selects target or pc_plus4.
// start->done takes 2 + wait cycles (1 on misaligned address); start is ignored while busy.
module mem_cond_branch #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             reset,
  mem_cond_branch_if.slave bus
);

  localparam int         ALIGN_BITS = $clog2(DATA_WIDTH / 8);
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;

  state_t                r_state;
  logic [2:0]            r_cond;
  logic [ADDR_WIDTH-1:0] r_pc_plus4;
  logic [ADDR_WIDTH-1:0] r_target;
  logic [7:0]            r_wait_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_taken;
  logic                  r_fault;
  logic                  r_rf_we;
  logic                  r_mem_req;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [ADDR_WIDTH-1:0] r_next_pc;
  logic [DATA_WIDTH-1:0] r_load_value;

  logic [ADDR_WIDTH-1:0] w_offset_sext;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_misaligned;
  logic                  w_cond_hit;

  // Zero counts as neither negative nor positive; the sign bit alone marks negative.
  function automatic logic cond_eval(input logic [2:0] c, input logic [DATA_WIDTH-1:0] v);
    logic is_neg;
    logic is_zero;
    logic hit;
    is_neg  = v[DATA_WIDTH-1];
    is_zero = (v == '0);
    hit     = 1'b0;
    case (c)
      3'd0:    hit = is_neg;
      3'd1:    hit = is_zero;
      3'd2:    hit = !is_zero;
      3'd3:    hit = !is_neg && !is_zero;
      3'd4:    hit = !is_neg;
      3'd5:    hit = is_neg || is_zero;
      3'd6:    hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  assign w_offset_sext = {{(ADDR_WIDTH-16){bus.offset[15]}}, bus.offset};
  assign w_addr        = bus.base + w_offset_sext;
  assign w_misaligned  = |w_addr[ALIGN_BITS-1:0];
  assign w_cond_hit    = cond_eval(r_cond, bus.mem_rdata);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cond       <= '0;
      r_pc_plus4   <= '0;
      r_target     <= '0;
      r_wait_cnt   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_taken      <= 1'b0;
      r_fault      <= 1'b0;
      r_rf_we      <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_next_pc    <= '0;
      r_load_value <= '0;
    end else begin
      // Single-cycle pulses fall back to zero unless a transition below re-arms them.
      r_done     <= 1'b0;
      r_rf_we    <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_cond     <= bus.cond;
            r_pc_plus4 <= bus.pc_plus4;
            r_target   <= bus.target;
            r_busy     <= 1'b1;
            r_taken    <= 1'b0;
            if (w_misaligned) begin
              r_state   <= ST_DONE;
              r_fault   <= 1'b1;
              r_done    <= 1'b1;
              r_next_pc <= bus.pc_plus4;
            end else begin
              r_state    <= ST_REQ;
              r_fault    <= 1'b0;
              r_mem_req  <= 1'b1;
              r_mem_addr <= w_addr;
            end
          end
        end
        ST_REQ: begin
          r_state    <= ST_WAIT;
          r_wait_cnt <= '0;
        end
        ST_WAIT: begin
          if (bus.mem_ready) begin
            r_state      <= ST_DONE;
            r_load_value <= bus.mem_rdata;
            r_taken      <= w_cond_hit;
            r_next_pc    <= w_cond_hit ? r_target : r_pc_plus4;
            r_done       <= 1'b1;
            r_rf_we      <= 1'b1;
          end else if (r_wait_cnt == WAIT_LAST) begin
            // Give up; load_value keeps whatever the last good read left there.
            r_state   <= ST_DONE;
            r_fault   <= 1'b1;
            r_taken   <= 1'b0;
            r_next_pc <= r_pc_plus4;
            r_done    <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req    = r_mem_req;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.taken      = r_taken;
  assign bus.fault      = r_fault;
  assign bus.next_pc    = r_next_pc;
  assign bus.load_value = r_load_value;
  assign bus.rf_we      = r_rf_we;

endmodule

// File: tb/tb_mem_cond_branch.sv
// Bench for mem_cond_branch: a timeline model per command checked every cycle,
// plus literal expectations for the headline scenarios.
module tb_mem_cond_branch;
  localparam int TO = 15;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;

  mem_cond_branch_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  mem_cond_branch #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model of the command in flight: its start cycle, total latency and results.
  bit          chk_en;
  bit          m_active;
  int          m_t0;
  int          m_L;
  bit          m_mis;
  logic [31:0] m_addr;
  bit          m_taken;
  bit          m_fault;
  logic [31:0] m_next_pc;
  logic [31:0] m_load;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_cond(input logic [2:0] c, input logic [31:0] v);
    int s;
    s = $signed(v);
    case (c)
      3'd0:    return s < 0;
      3'd1:    return s == 0;
      3'd2:    return s != 0;
      3'd3:    return s > 0;
      3'd4:    return s >= 0;
      3'd5:    return s <= 0;
      3'd6:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  int cmp_k;
  bit e_busy;
  bit e_done;
  bit e_req;

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_k  = m_active ? (cyc - m_t0) : -1000;
      e_busy = m_active && cmp_k >= 1 && cmp_k <= m_L;
      e_done = m_active && cmp_k == m_L;
      e_req  = m_active && cmp_k == 1 && !m_mis;
      chk("busy", 64'(bus.busy), 64'(e_busy));
      chk("done", 64'(bus.done), 64'(e_done));
      chk("rf_we", 64'(bus.rf_we), 64'(e_done && !m_fault));
      chk("mem_req", 64'(bus.mem_req), 64'(e_req));
      chk("mem_addr", 64'(bus.mem_addr), e_req ? 64'(m_addr) : 64'd0);
      if (!m_active || cmp_k >= m_L) begin
        chk("taken", 64'(bus.taken), 64'(m_taken));
        chk("fault", 64'(bus.fault), 64'(m_fault));
        chk("next_pc", 64'(bus.next_pc), 64'(m_next_pc));
        chk("load_value", 64'(bus.load_value), 64'(m_load));
      end
    end
  end

  // w = WAIT cycle on which mem_ready is given (0 = never); called at posedge+1.
  task automatic run_txn(input logic [2:0] c, input logic [31:0] b, input logic [15:0] off,
                         input logic [31:0] pc4, input logic [31:0] tg, input int w,
                         input logic [31:0] rd, input bit early_rdy, input int exp_lat);
    logic [31:0] a;
    int          lat;
    a      = b + 32'($signed(off));
    m_mis  = (a % 4) != 0;
    m_addr = a;
    if (m_mis) begin
      m_L = 1;  m_fault = 1'b1;
    end else if (w == 0) begin
      m_L = 2 + TO;  m_fault = 1'b1;
    end else begin
      m_L = 2 + w;  m_fault = 1'b0;  m_load = rd;
    end
    m_taken   = !m_fault && model_cond(c, rd);
    m_next_pc = m_taken ? tg : pc4;
    m_t0      = cyc;
    m_active  = 1'b1;
    bus.cond = c;  bus.base = b;  bus.offset = off;  bus.pc_plus4 = pc4;  bus.target = tg;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.cond = 3'($urandom_range(0, 7));
    bus.base = $urandom;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        lat = cyc - m_t0;
        break;
      end
      if (w > 0 && cyc == m_t0 + 1 + w) begin
        bus.mem_ready = 1'b1;  bus.mem_rdata = rd;
      end else if (early_rdy && cyc == m_t0 + 1) begin
        bus.mem_ready = 1'b1;  bus.mem_rdata = 32'hDEAD_BEEF;
      end else begin
        bus.mem_ready = 1'b0;  bus.mem_rdata = 32'hBAD0_0000 ^ 32'(cyc);
      end
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b0;
    chk("latency", 64'(lat), 64'(exp_lat));
    @(posedge clk); #1;
  endtask

  logic [31:0] sv[4];
  logic [7:0]  tbl[4];
  logic [7:0]  tbl_row;

  initial begin
    total = 0;  bad = 0;  chk_en = 1'b0;  m_active = 1'b0;
    m_taken = 1'b0;  m_fault = 1'b0;  m_next_pc = '0;  m_load = '0;  m_t0 = 0;  m_L = 1;
    m_mis = 1'b0;  m_addr = '0;
    bus.start = 1'b1;  bus.cond = 3'd6;  bus.base = 32'h10;  bus.offset = 16'h0;
    bus.pc_plus4 = 32'h0;  bus.target = 32'h0;  bus.mem_ready = 1'b0;  bus.mem_rdata = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_next_pc", 64'(bus.next_pc), 64'd0);
    chk("rst_load", 64'(bus.load_value), 64'd0);
    bus.start = 1'b0;
    reset = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    run_txn(3'd0, 32'h8, 16'h0, 32'h1000, 32'h2000, 1, 32'hFFFF_FFFC, 1'b0, 3);
    chk("p35_load", 64'(bus.load_value), 64'hFFFF_FFFC);
    chk("p35_taken", 64'(bus.taken), 64'd1);
    chk("p35_next_pc", 64'(bus.next_pc), 64'h2000);

    run_txn(3'd0, 32'h4, 16'h8, 32'h1004, 32'h2004, 2, 32'd24, 1'b0, 4);
    chk("p36_taken", 64'(bus.taken), 64'd0);
    chk("p36_next_pc", 64'(bus.next_pc), 64'h1004);
    chk("p36_load", 64'(bus.load_value), 64'd24);

    run_txn(3'd6, 32'h9, 16'h0, 32'h1008, 32'h2008, 1, 32'd1, 1'b0, 1);
    chk("p37_fault", 64'(bus.fault), 64'd1);
    chk("p37_taken", 64'(bus.taken), 64'd0);
    chk("p37_load", 64'(bus.load_value), 64'd24);

    run_txn(3'd6, 32'h20, 16'hFFFE, 32'h100C, 32'h200C, 1, 32'd1, 1'b0, 1);
    run_txn(3'd2, 32'h20, 16'hFFFC, 32'h1010, 32'h2010, 3, 32'd7, 1'b0, 5);
    run_txn(3'd3, 32'hFFFF_FFFC, 16'h8, 32'h1014, 32'h2014, 1, 32'h55, 1'b0, 3);
    run_txn(3'd4, 32'h30, 16'h0, 32'h1018, 32'h2018, TO, 32'd5, 1'b0, 17);
    chk("last_wait_fault", 64'(bus.fault), 64'd0);
    run_txn(3'd4, 32'h34, 16'h0, 32'h101C, 32'h201C, 1, 32'h55, 1'b0, 3);

    run_txn(3'd6, 32'h100, 16'h0, 32'h1020, 32'h2020, 0, 32'd0, 1'b1, 17);
    chk("p38_fault", 64'(bus.fault), 64'd1);
    chk("p38_load", 64'(bus.load_value), 64'h55);
    chk("p38_next_pc", 64'(bus.next_pc), 64'h1020);
    bus.mem_ready = 1'b1;  bus.mem_rdata = 32'hAAAA_AAAA;
    repeat (2) begin
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b0;
    chk("late_ready_load", 64'(bus.load_value), 64'h55);

    // Reset lands while the read is outstanding.
    chk_en = 1'b0;
    bus.cond = 3'd6;  bus.base = 32'h80;  bus.offset = 16'h0;  bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_busy0", 64'(bus.busy), 64'd0);
    chk("mid_done0", 64'(bus.done), 64'd0);
    chk("mid_rf_we0", 64'(bus.rf_we), 64'd0);
    chk("mid_fault0", 64'(bus.fault), 64'd0);
    chk("mid_taken0", 64'(bus.taken), 64'd0);
    chk("mid_next_pc0", 64'(bus.next_pc), 64'd0);
    chk("mid_load0", 64'(bus.load_value), 64'd0);
    chk("mid_mem_addr0", 64'(bus.mem_addr), 64'd0);
    reset = 1'b0;
    bus.mem_ready = 1'b1;  bus.mem_rdata = 32'h1234_5678;
    m_active = 1'b0;  m_taken = 1'b0;  m_fault = 1'b0;  m_next_pc = '0;  m_load = '0;
    chk_en = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;

    run_txn(3'd1, 32'h80, 16'h0, 32'h1100, 32'h2100, 1, 32'd0, 1'b0, 3);
    chk("post_rst_taken", 64'(bus.taken), 64'd1);

    sv[0] = 32'd0;  sv[1] = 32'd1;  sv[2] = 32'h8000_0000;  sv[3] = 32'hFFFF_FFFF;
    tbl[0] = 8'h72;  tbl[1] = 8'h5C;  tbl[2] = 8'h65;  tbl[3] = 8'h65;
    for (int vi = 0; vi < 4; vi++) begin
      for (int c = 0; c < 8; c++) begin
        int n;
        n = vi * 8 + c;
        run_txn(3'(c), 32'h40 + 32'(n * 4), 16'h0, 32'h3000 + 32'(n * 4),
                32'h5000 + 32'(n * 4), 1 + (n % 3), sv[vi], 1'b0, 3 + (n % 3));
        tbl_row = tbl[vi];
        chk("tbl_taken", 64'(bus.taken), 64'(tbl_row[c]));
      end
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
